// File: rtl/alu_pkg.sv
// Shared types and default sizing for the ALU issue/writeback slice.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SHL = 3'd5,
    SHR = 3'd6,
    CMP = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } issue_state_t;

  localparam int ALU_DATA_W  = 8;
  localparam int ALU_NREGS   = 4;
  localparam int ALU_ADDR_W  = $clog2(ALU_NREGS);
  localparam int ALU_INSTR_W = 3 + 2 * ALU_ADDR_W;

  // Instruction layout {op, rd, rs}, LSB offsets of each field.
  localparam int INSTR_RS_LSB = 0;
  localparam int INSTR_RD_LSB = ALU_ADDR_W;
  localparam int INSTR_OP_LSB = 2 * ALU_ADDR_W;

endpackage

// File: rtl/alu.sv
// Combinational 8-op ALU; shifts are by one and ignore r1, cmp is equality.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] r0_i,
  input  logic [DATA_W-1:0] r1_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ADD:     result_o = r0_i + r1_i;
      SUB:     result_o = r0_i - r1_i;
      AND:     result_o = r0_i & r1_i;
      OR:      result_o = r0_i | r1_i;
      XOR:     result_o = r0_i ^ r1_i;
      SHL:     result_o = r0_i << 1;
      SHR:     result_o = r0_i >> 1;
      CMP:     result_o = {{(DATA_W-1){1'b0}}, (r0_i == r1_i)};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// NREGS x DATA_W register file: two async read ports, one sync write port, async clear.
module reg_file #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr0_i,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer: IDLE -> READ -> EXEC -> WB around an external combinational ALU.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int NREGS   = ALU_NREGS,
  parameter int ADDR_W  = $clog2(NREGS),
  parameter int INSTR_W = 3 + 2 * ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               ld_en,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  output logic [2:0]         alu_op,
  output logic [DATA_W-1:0]  alu_r0,
  output logic [DATA_W-1:0]  alu_r1,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               zero
);

  issue_state_t       state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [2:0]         alu_op_q;
  logic [DATA_W-1:0]  alu_r0_q, alu_r1_q, res_q, result_q;
  logic               zero_q;

  logic [2:0]         op_w;
  logic [ADDR_W-1:0]  rd_w, rs_w;
  logic [DATA_W-1:0]  rd_data_w, rs_data_w;
  logic               accept_w;
  logic               rf_we_w;
  logic [ADDR_W-1:0]  rf_waddr_w;
  logic [DATA_W-1:0]  rf_wdata_w;

  assign op_w = instr_q[INSTR_W-1 -: 3];
  assign rd_w = instr_q[2*ADDR_W-1 -: ADDR_W];
  assign rs_w = instr_q[ADDR_W-1:0];

  assign instr_ready = (state_q == IDLE);
  assign accept_w    = instr_valid && instr_ready;
  assign done        = (state_q == WB);

  // Writeback owns the write port; a preload only lands in an idle cycle with no offer.
  assign rf_we_w    = (state_q == WB) || ((state_q == IDLE) && ld_en && !instr_valid);
  assign rf_waddr_w = (state_q == WB) ? rd_w  : ld_addr;
  assign rf_wdata_w = (state_q == WB) ? res_q : ld_data;

  reg_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (rf_we_w),
    .waddr_i  (rf_waddr_w),
    .wdata_i  (rf_wdata_w),
    .raddr0_i (rd_w),
    .rdata0_o (rd_data_w),
    .raddr1_i (rs_w),
    .rdata1_o (rs_data_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_w) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      alu_op_q <= '0;
      alu_r0_q <= '0;
      alu_r1_q <= '0;
      res_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept_w) instr_q <= instr;
      if (state_q == READ) begin
        alu_op_q <= op_w;
        alu_r0_q <= rd_data_w;
        alu_r1_q <= rs_data_w;
      end
      if (state_q == EXEC) res_q <= alu_result;
      if (state_q == WB) begin
        result_q <= res_q;
        zero_q   <= (res_q == '0);
      end
    end
  end

  assign alu_op = alu_op_q;
  assign alu_r0 = alu_r0_q;
  assign alu_r1 = alu_r1_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl driving the real alu.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [6:0] instr;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [2:0] alu_op;
  logic [7:0] alu_r0, alu_r1, alu_result;
  logic       done;
  logic [7:0] result;
  logic       zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu u_alu (
    .op_i     (alu_op),
    .r0_i     (alu_r0),
    .r1_i     (alu_r1),
    .result_o (alu_result)
  );

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .alu_op      (alu_op),
    .alu_r0      (alu_r0),
    .alu_r1      (alu_r1),
    .alu_result  (alu_result),
    .done        (done),
    .result      (result),
    .zero        (zero)
  );

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] vrd;
    logic [7:0] vrs;
    logic [7:0] exp;
    logic       ez;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                              input logic [7:0] vrd, input logic [7:0] vrs,
                              input logic [7:0] exp, input logic ez);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.vrd = vrd; v.vrs = vrs; v.exp = exp; v.ez = ez;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rf(input int i);
    return dut.u_rf.mem_q[i];
  endfunction

  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    instr_valid = 1'b0;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [7:0] exp, input logic ez);
    @(negedge clk);
    chk({nm, " ready_idle"}, instr_ready, 1);
    instr_valid = 1'b1;
    instr = {op, rd, rs};
    @(negedge clk);
    instr_valid = 1'b0;
    chk({nm, " done_T1"}, done, 0);
    chk({nm, " ready_T1"}, instr_ready, 0);
    @(negedge clk);
    chk({nm, " alu_op"}, alu_op, op);
    chk({nm, " done_T2"}, done, 0);
    @(negedge clk);
    chk({nm, " done_T3"}, done, 1);
    @(negedge clk);
    chk({nm, " done_T4"}, done, 0);
    chk({nm, " result"}, result, exp);
    chk({nm, " zero"}, zero, ez);
    chk({nm, " reg_rd"}, rf(rd), exp);
  endtask

  initial begin
    vecs[0]  = mk(ADD, 2'd0, 2'd1, 8'h05, 8'h03, 8'h08, 1'b0);
    vecs[1]  = mk(ADD, 2'd2, 2'd3, 8'hF0, 8'h20, 8'h10, 1'b0);
    vecs[2]  = mk(SUB, 2'd2, 2'd2, 8'h10, 8'h10, 8'h00, 1'b1);
    vecs[3]  = mk(SUB, 2'd1, 2'd0, 8'h00, 8'h01, 8'hFF, 1'b0);
    vecs[4]  = mk(AND, 2'd3, 2'd0, 8'hCC, 8'hAA, 8'h88, 1'b0);
    vecs[5]  = mk(OR,  2'd0, 2'd2, 8'hC0, 8'h0A, 8'hCA, 1'b0);
    vecs[6]  = mk(XOR, 2'd1, 2'd3, 8'hFF, 8'h0F, 8'hF0, 1'b0);
    vecs[7]  = mk(SHL, 2'd2, 2'd1, 8'h81, 8'h55, 8'h02, 1'b0);
    vecs[8]  = mk(SHR, 2'd3, 2'd2, 8'h81, 8'h55, 8'h40, 1'b0);
    vecs[9]  = mk(CMP, 2'd0, 2'd1, 8'h08, 8'h03, 8'h00, 1'b1);
    vecs[10] = mk(CMP, 2'd1, 2'd1, 8'h01, 8'h01, 8'h01, 1'b0);
    vecs[11] = mk(CMP, 2'd2, 2'd3, 8'h77, 8'h77, 8'h01, 1'b0);

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);
    chk("rst ready", instr_ready, 1);
    chk("rst done", done, 0);
    chk("rst alu_op", alu_op, 0);
    chk("rst alu_r0", alu_r0, 0);
    chk("rst alu_r1", alu_r1, 0);
    chk("rst result", result, 0);
    chk("rst zero", zero, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("rst reg%0d", i), rf(i), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      preload(vecs[i].rd, vecs[i].vrd);
      if (vecs[i].rs != vecs[i].rd) preload(vecs[i].rs, vecs[i].vrs);
      issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].exp, vecs[i].ez);
    end

    // valid held high: three dependent ADDs r0 += r1 at one per four cycles
    preload(2'd0, 8'h01);
    preload(2'd1, 8'h02);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {ADD, 2'd0, 2'd1};
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("b2b ready k%0d", k), instr_ready, (k % 4 == 0) ? 1 : 0);
      chk($sformatf("b2b done k%0d", k), done, (k % 4 == 3) ? 1 : 0);
      if (k == 9) instr_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b done_end", done, 0);
    chk("b2b result", result, 8'h07);
    chk("b2b reg0", rf(0), 8'h07);

    // load offered with the accept and during READ/EXEC/WB must be dropped
    preload(2'd1, 8'h33);
    preload(2'd0, 8'h44);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {OR, 2'd0, 2'd0};
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'hAA;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("ld busy done", done, 1);
    ld_en = 1'b0;
    @(negedge clk);
    chk("ld busy reg1", rf(1), 8'h33);
    chk("ld busy result", result, 8'h44);
    preload(2'd1, 8'hAA);
    chk("ld idle reg1", rf(1), 8'hAA);

    // reset asserted while in EXEC
    preload(2'd0, 8'h12);
    preload(2'd1, 8'h34);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {ADD, 2'd0, 2'd1};
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid alu_r0 pre", alu_r0, 8'h12);
    rst_n = 1'b0;
    #1;
    chk("mid ready", instr_ready, 1);
    chk("mid done", done, 0);
    chk("mid alu_op", alu_op, 0);
    chk("mid alu_r0", alu_r0, 0);
    chk("mid alu_r1", alu_r1, 0);
    chk("mid result", result, 0);
    chk("mid zero", zero, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("mid reg%0d", i), rf(i), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      chk($sformatf("mid no_done k%0d", k), done, 0);
    end
    chk("mid reg0 after", rf(0), 0);

    preload(2'd3, 8'h21);
    preload(2'd2, 8'h09);
    issue("post_rst", SUB, 2'd3, 2'd2, 8'h18, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
